// File: rtl/multi_add_ctrl_if.sv
// rtl/multi_add_ctrl_if.sv - command/result bundle for the byte-serial multi-byte adder
interface multi_add_ctrl_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic                  sub;
  logic                  cin;
  logic                  abort;
  logic [8*NBYTES-1:0]   x;
  logic [8*NBYTES-1:0]   y;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   s;
  logic                  cout;
  logic                  ovf;

  modport master (
    output start, sub, cin, abort, x, y,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, cin, abort, x, y,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/multi_add_ctrl.sv
// rtl/multi_add_ctrl.sv - byte-serial add/subtract controller around one 8-bit ripple-carry adder
module RCA8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic w_c;

  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < 8; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end
endmodule

module multi_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  multi_add_ctrl_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_idx;
  logic           r_carry;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic           r_sub;
  logic [W-1:0]   r_s;
  logic           r_cout;
  logic           r_ovf;
  logic           r_done;

  logic [7:0]     w_a;
  logic [7:0]     w_b;
  logic [7:0]     w_sum;
  logic           w_cout;
  logic           w_last;
  logic           w_ybm;

  assign w_a    = r_x[{r_idx, 3'b000} +: 8];
  assign w_b    = r_sub ? ~r_y[{r_idx, 3'b000} +: 8] : r_y[{r_idx, 3'b000} +: 8];
  assign w_last = (r_idx == IW'(NBYTES - 1));
  // Sign bit of the operand actually fed to the adder (inverted for subtract).
  assign w_ybm  = r_sub ? ~r_y[W-1] : r_y[W-1];

  RCA8bit u_rca (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_ADD;
      ST_ADD: begin
        if (bus.abort)   w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sub   <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_x     <= bus.x;
            r_y     <= bus.y;
            r_sub   <= bus.sub;
            r_idx   <= '0;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
          end
        end
        ST_ADD: begin
          if (!bus.abort) begin
            r_s[{r_idx, 3'b000} +: 8] <= w_sum;
            r_carry                   <= w_cout;
            if (!w_last) r_idx <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          // Flags are published together with the done pulse so an abort never disturbs them.
          r_done <= 1'b1;
          r_cout <= r_carry;
          r_ovf  <= (r_x[W-1] == w_ybm) && (r_s[W-1] != r_x[W-1]);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_ADD);
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_multi_add_ctrl.sv
// tb/tb_multi_add_ctrl.sv - directed self-checking bench for multi_add_ctrl with NBYTES=4
module tb_multi_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc;
  int          ndone;
  logic [31:0] cap_s;

  always #5 clk = ~clk;

  multi_add_ctrl_if #(.NBYTES(4)) bus ();

  multi_add_ctrl #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    check({tag, ".s"},    bus.s,           es);
    check({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, ec});
    check({tag, ".ovf"},  {31'd0, bus.ovf},  {31'd0, eo});
  endtask

  // Called at a negedge while IDLE; returns at the negedge where done is seen.
  task automatic do_op(input logic sb, input logic ci, input logic [31:0] xa, input logic [31:0] yb);
    bus.start = 1'b1;
    bus.sub   = sb;
    bus.cin   = ci;
    bus.x     = xa;
    bus.y     = yb;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.abort = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check_res("rst", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    check("add_wrap.latency", cyc, 32'd5);
    check_res("add_wrap", 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    check("add_wrap.pulse", {31'd0, bus.done}, 32'd0);

    do_op(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007);
    check_res("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
    check_res("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    @(negedge clk);
    do_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000);
    check_res("add_cin_ovf", 32'h8000_0000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_res("hold", 32'h8000_0000, 1'b0, 1'b1);

    // Second start and operand changes while ADD is running must be ignored.
    bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.x = 32'h1234_5678; bus.y = 32'h1111_1111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b1; bus.cin = 1'b1;
    bus.x = 32'hFFFF_FFFF; bus.y = 32'h0F0F_0F0F;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    cap_s = '0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        cap_s = bus.s;
      end
    end
    check("ignore.ndone", ndone, 32'd1);
    check("ignore.s", cap_s, 32'h2345_6789);
    check_res("ignore", 32'h2345_6789, 1'b0, 1'b0);

    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
    check_res("pre_abort", 32'h7FFF_FFFF, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.x = 32'h0000_0001; bus.y = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort.busy", {31'd0, bus.busy}, 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("abort.ndone", ndone, 32'd0);
    check("abort.cout", {31'd0, bus.cout}, 32'd1);
    check("abort.ovf", {31'd0, bus.ovf}, 32'd1);
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0001);
    check("post_abort.latency", cyc, 32'd5);
    check_res("post_abort", 32'h0000_0001, 1'b1, 1'b1);
    @(negedge clk);

    bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.x = 32'h1111_1111; bus.y = 32'h2222_2222;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.busy", {31'd0, bus.busy}, 32'd0);
    check("arst.done", {31'd0, bus.done}, 32'd0);
    check_res("arst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002);
    check("b2b0.latency", cyc, 32'd5);
    check_res("b2b0", 32'h0000_0003, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020);
    check("b2b1.period", cyc + 1, 32'd6);
    check_res("b2b1", 32'hFFFF_FFF0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h2152_4110);
    check("b2b2.period", cyc + 1, 32'd6);
    check_res("b2b2", 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/multi_add_ctrl.md
MULTI_ADD_CTRL -- requirements
Module: multi_add_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes; legal range is 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1 bit: 0 means add, 1 means subtract (x - y); sampled with start.
REQ-006 SHALL have port cin, input, 1 bit: carry-in for add; ignored when sub=1.
REQ-007 SHALL have port x, input, 8*NBYTES bits: operand A; sampled with start.
REQ-008 SHALL have port y, input, 8*NBYTES bits: operand B; sampled with start.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-010 SHALL have port busy, output, 1 bit: high while in state ADD.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 SHALL have port s, output, 8*NBYTES bits: the result.
REQ-013 SHALL have port cout, output, 1 bit: final carry-out, which is the inverted borrow in subtract mode.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the full-width result.

Function
REQ-015 SHALL compute the result one byte per cycle, least significant byte first, using exactly one instance of the team's 8-bit ripple-carry adder (RCA8bit).
REQ-016 SHALL implement the states IDLE, ADD and DONE.
REQ-017 In IDLE with start=1, SHALL latch x, y, sub and cin, clear byte index idx to 0, load the carry register with (sub ? 1 : cin), and go to ADD.
REQ-018 In ADD, SHALL drive the adder with x_q[idx], (sub ? ~y_q[idx] : y_q[idx]) and the carry register; SHALL write the adder sum to s byte idx and the adder carry-out to the carry register.
REQ-019 In ADD, when idx == NBYTES-1, SHALL go to DONE; otherwise SHALL increment idx.
REQ-020 In DONE, SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 cout SHALL equal the final carry register.
REQ-022 ovf SHALL be 1 when the MSBs of A and of the effective B are equal and the MSB of s differs from them.
REQ-023 Latency: start accepted at edge T; done is high in the cycle following edge T+NBYTES+1; total NBYTES+2 cycles from start to return to IDLE.
REQ-024 A new start SHALL be accepted in the IDLE cycle immediately after DONE, giving back-to-back throughput of one operation per NBYTES+2 cycles.
REQ-025 start SHALL be ignored in ADD and DONE; no queuing; latched operands SHALL be unaffected.
REQ-026 s, cout and ovf SHALL hold their last completed values through IDLE until the next DONE.
REQ-027 During ADD, s bytes are partially updated and SHALL NOT be treated as valid; only done qualifies them.
REQ-028 abort=1 in ADD SHALL return the block to IDLE on the next edge with no done pulse and cout/ovf unchanged; s bytes already written are undefined for use.
REQ-029 abort in IDLE or DONE SHALL have no effect; DONE still pulses.
REQ-030 If abort and start are both high in IDLE, start SHALL be accepted.
REQ-031 Input changes on x, y, sub or cin after the start cycle SHALL NOT affect the operation in flight.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, idx=0, carry register 0, busy=0, done=0, s=0, cout=0 and ovf=0, regardless of the clock.
REQ-033 Reset asserted mid-ADD SHALL discard the operation with no done pulse; after deassertion, the first start SHALL behave as from power-up.

Verification (NBYTES=4)
REQ-034 Bench SHALL check: add, x=0xFFFFFFFF, y=0x00000001, cin=0 -> done at start+5 cycles, s=0x00000000, cout=1, ovf=0.
REQ-035 Bench SHALL check: sub, x=0x00000005, y=0x00000007 -> s=0xFFFFFFFE, cout=0, ovf=0; and sub, x=0x80000000, y=0x00000001 -> s=0x7FFFFFFF, cout=1, ovf=1.
REQ-036 Bench SHALL check: add, x=0x7FFFFFFF, y=0x00000000, cin=1 -> s=0x80000000, cout=0, ovf=1.
REQ-037 Bench SHALL check: a second start pulsed during ADD with different operands -> ignored, first result unchanged, exactly one done pulse.
REQ-038 Bench SHALL check: abort in the 2nd ADD cycle -> no done, busy low next cycle, prior s/cout/ovf retained; then a new start completes correctly.
REQ-039 Bench SHALL check: rst_n pulsed low mid-ADD asynchronously -> all outputs 0 immediately; back-to-back starts after reset give done every 6 cycles with correct results.
